// File: rtl/fp_div_rr_sched.sv
// fp_div_rr_sched: round-robin scheduler that shares one sequential int16->fp32
// divider core (start pulse in, complete pulse out) among N requesters and returns
// the tagged fp32 quotient over a valid/ready response channel.
// Optional feature: define FPDIV_SCHED_TIMEOUT_EN to abort a division that has not
// completed within TIMEOUT_CYC WAIT cycles (response qNaN, status 8'h80).
module fp_div_rr_sched #(
    parameter int N           = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic [N-1:0]      req_ready,
    output logic              div_start,
    output logic [15:0]       div_a,
    output logic [15:0]       div_b,
    input  logic [31:0]       div_z,
    input  logic [7:0]        div_status,
    input  logic              div_complete,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic [7:0]        rsp_status
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [N-1:0]    req_ready_q, req_ready_d;
    logic            div_start_q, div_start_d;
    logic [15:0]     div_a_q, div_a_d;
    logic [15:0]     div_b_q, div_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [7:0]      rsp_status_q, rsp_status_d;

`ifdef FPDIV_SCHED_TIMEOUT_EN
    logic [4:0]      wait_cnt_q, wait_cnt_d;
`endif

    logic            found;
    logic [IDW-1:0]  winner;
    logic [15:0]     win_a;
    logic [15:0]     win_b;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_idx;

    // Pick the first pending requester at or after rr_ptr (wrapping mod N) and mux its operands
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_a    = '0;
        win_b    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(N)) begin
                scan_sum = scan_sum - (IDW+1)'(N);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (winner == IDW'(i)) begin
                win_a = req_a[16*i +: 16];
                win_b = req_b[16*i +: 16];
            end
        end
    end

    // Next-state and registered-output logic for IDLE -> ISSUE -> WAIT -> RESP
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        req_ready_d  = '0;
        div_start_d  = 1'b0;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
`ifdef FPDIV_SCHED_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d             = S_ISSUE;
                    req_ready_d[winner] = 1'b1;
                    div_start_d         = 1'b1;
                    div_a_d             = win_a;
                    div_b_d             = win_b;
                    grant_id_d          = winner;
                    rr_ptr_d            = (winner == IDW'(N-1)) ? '0 : winner + IDW'(1);
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FPDIV_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (div_complete) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = grant_id_q;
                    rsp_data_d   = div_z;
                    rsp_status_d = div_status;
`ifdef FPDIV_SCHED_TIMEOUT_EN
                end else if (wait_cnt_q == 5'(TIMEOUT_CYC - 1)) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = grant_id_q;
                    rsp_data_d   = 32'h7FC0_0000;
                    rsp_status_d = 8'h80;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            req_ready_q  <= '0;
            div_start_q  <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            req_ready_q  <= req_ready_d;
            div_start_q  <= div_start_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

`ifdef FPDIV_SCHED_TIMEOUT_EN
    // WAIT-cycle counter for the scheduler timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign req_ready  = req_ready_q;
    assign div_start  = div_start_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;

endmodule
